// File: rtl/awg_dac_pkg.sv
// Shared types and helpers for the dual-channel DAC serial driver:
// frame geometry, driver state encoding and frame-word assembly.
package awg_dac_pkg;

    localparam int FRAME_W = 16;
    localparam int DATA_W  = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Frame word: two leading zeros, power-down mode, then the 12-bit sample.
    function automatic logic [FRAME_W-1:0] make_frame(input logic [1:0]        pd_mode,
                                                      input logic [DATA_W-1:0] sample);
        return {2'b00, pd_mode, sample};
    endfunction

endpackage

// File: rtl/dac_spi_driver_sclk_gen.sv
// SCLK divider: counts CLK_DIV clk cycles per half-period while enabled and
// flags the edge on which SCLK will rise or fall. SCLK parks high when disabled.
module dac_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             wrap;

    assign wrap = en && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign fall = wrap && sclk;
    assign rise = wrap && !sclk;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div_cnt <= '0;
            sclk    <= 1'b1;
        end else if (wrap) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dac_spi_driver.sv
// Dual DAC121S101 serial driver: shifts channel A/B frame words in lockstep
// under a shared SYNC/SCLK. Optional one-entry skid buffer: DAC_SKID_BUF_EN.
module dac_spi_driver
    import awg_dac_pkg::*;
#(
    parameter int         CLK_DIV    = 2,
    parameter int         GAP_CYCLES = 2,
    parameter logic [1:0] PD_MODE    = 2'b00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_a,
    input  logic [DATA_W-1:0] sample_b,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              dac_sync,
    output logic              dac_sclk,
    output logic              dac_d0,
    output logic              dac_d1,
    output logic              busy,
    output logic              frame_done
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t             state, state_next;
    logic [FRAME_W-1:0] shreg_a, shreg_b;
    logic [FRAME_W-1:0] load_a, load_b;
    logic [4:0]         bit_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               sclk_rise, sclk_fall;
    logic               take, launch, shift_end, gap_last;

    dac_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state == SHIFT),
        .sclk (dac_sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    assign busy      = (state != IDLE);
    assign take      = sample_valid && sample_ready;
    assign gap_last  = (state == GAP) && (gap_cnt == GAP_W'(GAP_CYCLES - 1));
    // The rising toggle after the 16th falling edge closes the frame.
    assign shift_end = sclk_rise && (bit_cnt == 5'(FRAME_W));

`ifdef DAC_SKID_BUF_EN
    logic               hold_full;
    logic [FRAME_W-1:0] hold_a, hold_b;
    logic               drain;

    assign drain        = gap_last && hold_full;
    assign sample_ready = !rst && (!hold_full || drain);
    // A held pair always launches first; an empty holder lets a fresh pair launch from IDLE or GAP end.
    assign launch       = ((state == IDLE) && take) || (gap_last && (hold_full || take));
    assign load_a       = hold_full ? hold_a : make_frame(PD_MODE, sample_a);
    assign load_b       = hold_full ? hold_b : make_frame(PD_MODE, sample_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full <= 1'b0;
            hold_a    <= '0;
            hold_b    <= '0;
        end else if (take && busy && !(gap_last && !hold_full)) begin
            hold_full <= 1'b1;
            hold_a    <= make_frame(PD_MODE, sample_a);
            hold_b    <= make_frame(PD_MODE, sample_b);
        end else if (drain) begin
            hold_full <= 1'b0;
        end
    end
`else
    assign sample_ready = !rst && (state == IDLE);
    assign launch       = (state == IDLE) && take;
    assign load_a       = make_frame(PD_MODE, sample_a);
    assign load_b       = make_frame(PD_MODE, sample_b);
`endif

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (launch)    state_next = SHIFT;
            SHIFT:   if (shift_end) state_next = GAP;
            GAP:     if (gap_last)  state_next = launch ? SHIFT : IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dac_sync   <= 1'b1;
            dac_d0     <= 1'b0;
            dac_d1     <= 1'b0;
            frame_done <= 1'b0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            shreg_a    <= '0;
            shreg_b    <= '0;
        end else begin
            state      <= state_next;
            frame_done <= shift_end;
            gap_cnt    <= ((state == GAP) && !gap_last) ? gap_cnt + 1'b1 : '0;
            if (launch) begin
                dac_sync <= 1'b0;
                shreg_a  <= load_a;
                shreg_b  <= load_b;
                dac_d0   <= load_a[FRAME_W-1];
                dac_d1   <= load_b[FRAME_W-1];
                bit_cnt  <= '0;
            end else if (shift_end) begin
                dac_sync <= 1'b1;
                dac_d0   <= 1'b0;
                dac_d1   <= 1'b0;
            end else if (state == SHIFT) begin
                if (sclk_fall) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
                // Data moves only while SCLK goes high, so it is stable across each falling edge.
                if (sclk_rise) begin
                    shreg_a <= shreg_a << 1;
                    shreg_b <= shreg_b << 1;
                    dac_d0  <= shreg_a[FRAME_W-2];
                    dac_d1  <= shreg_b[FRAME_W-2];
                end
            end
        end
    end

endmodule

// File: tb/tb_dac_spi_driver.sv
// Scoreboard bench for dac_spi_driver: a default instance (CLK_DIV=2, GAP=2)
// and a fast instance (CLK_DIV=1, GAP=1) watched by one shared bus monitor.
module tb_dac_spi_driver;

    localparam int GAP_S = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] sample_a, sample_b;
    logic        sample_valid;
    logic        sel;
    logic        valid_s, valid_f;

    logic ready_s, sync_s, sclk_s, d0_s, d1_s, busy_s, fdone_s;
    logic ready_f, sync_f, sclk_f, d0_f, d1_f, busy_f, fdone_f;
    logic m_ready, m_sync, m_sclk, m_d0, m_d1, m_busy, m_fdone;
    int   m_div;

    always #5 clk = ~clk;

    assign valid_s = sample_valid && !sel;
    assign valid_f = sample_valid && sel;

    dac_spi_driver #(.CLK_DIV(2), .GAP_CYCLES(GAP_S), .PD_MODE(2'b00)) u_dut (
        .clk(clk), .rst(rst), .sample_a(sample_a), .sample_b(sample_b),
        .sample_valid(valid_s), .sample_ready(ready_s), .dac_sync(sync_s),
        .dac_sclk(sclk_s), .dac_d0(d0_s), .dac_d1(d1_s), .busy(busy_s),
        .frame_done(fdone_s)
    );

    dac_spi_driver #(.CLK_DIV(1), .GAP_CYCLES(1), .PD_MODE(2'b00)) u_dut_fast (
        .clk(clk), .rst(rst), .sample_a(sample_a), .sample_b(sample_b),
        .sample_valid(valid_f), .sample_ready(ready_f), .dac_sync(sync_f),
        .dac_sclk(sclk_f), .dac_d0(d0_f), .dac_d1(d1_f), .busy(busy_f),
        .frame_done(fdone_f)
    );

    assign m_ready = sel ? ready_f : ready_s;
    assign m_sync  = sel ? sync_f  : sync_s;
    assign m_sclk  = sel ? sclk_f  : sclk_s;
    assign m_d0    = sel ? d0_f    : d0_s;
    assign m_d1    = sel ? d1_f    : d1_s;
    assign m_busy  = sel ? busy_f  : busy_s;
    assign m_fdone = sel ? fdone_f : fdone_s;
    assign m_div   = sel ? 1 : 2;

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input int obs, input int exp);
        compared++;
        if (obs != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [15:0] frame(input logic [11:0] s);
        return {4'b0000, s};
    endfunction

    // Expected {frame_a, frame_b} per accepted pair.
    logic [31:0] sb[$];
    logic [31:0] exp_w;
    int          gaps[$];

    logic        p_sync = 1'b1, p_sclk = 1'b1, p_d0 = 1'b0, p_d1 = 1'b0;
    int          low_len = 0, high_len = 0, nbits = 0;
    int          frames_done = 0, fd_count = 0, low_changes = 0;
    logic [15:0] got_a = '0, got_b = '0;

    // Bus monitor: collects bits on each SCLK falling edge while SYNC is low.
    always @(negedge clk) begin
        if (m_fdone) fd_count++;
        if (p_sync && !m_sync) begin
            gaps.push_back(high_len);
            low_len = 0;
            nbits   = 0;
            got_a   = '0;
            got_b   = '0;
        end
        if (!p_sync && m_sync) begin
            if (nbits == 16) begin
                if (sb.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                end else begin
                    exp_w = sb.pop_front();
                    check("frame_a", int'(got_a), int'(exp_w[31:16]));
                    check("frame_b", int'(got_b), int'(exp_w[15:0]));
                end
                check("sync_low_len", low_len, 32 * m_div);
                check("frame_done_on_rise", int'(m_fdone), 1);
                frames_done++;
            end else begin
                if (sb.size() != 0) void'(sb.pop_front());
                check("abort_no_frame_done", int'(m_fdone), 0);
            end
            high_len = 0;
        end
        if (m_sync) begin
            high_len++;
        end else begin
            low_len++;
            if (p_sclk && !m_sclk) begin
                got_a = {got_a[14:0], m_d0};
                got_b = {got_b[14:0], m_d1};
                nbits++;
            end else if (!p_sclk && !m_sclk && (m_d0 != p_d0 || m_d1 != p_d1)) begin
                low_changes++;
            end
        end
        p_sync = m_sync;
        p_sclk = m_sclk;
        p_d0   = m_d0;
        p_d1   = m_d1;
    end

    // Present a pair until accepted; returns on the negedge after the accepting edge.
    task automatic send(input logic [11:0] a, input logic [11:0] b);
        int n = 0;
        sample_a     = a;
        sample_b     = b;
        sample_valid = 1'b1;
        while (!m_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!m_ready) check("send_timeout", 0, 1);
        else          sb.push_back({frame(a), frame(b)});
        @(negedge clk);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sb.size() != 0 || m_busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("wait_done", int'(sb.size() == 0 && !m_busy), 1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, f0, fd0, n;
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_a     = '0;
        sample_b     = '0;
        sel          = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", int'(ready_s), 0);
        check("rst_sync",  int'(sync_s),  1);
        check("rst_sclk",  int'(sclk_s),  1);
        check("rst_data",  int'({d0_s, d1_s}), 0);
        check("rst_busy",  int'(busy_s),  0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", int'(ready_s), 1);

        // Idle hold
        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if (!(sync_s && sclk_s && !d0_s && !d1_s && !busy_s)) bad++;
            if (!(sync_f && sclk_f && !d0_f && !d1_f && !busy_f)) bad++;
        end
        check("idle_hold", bad, 0);

        // Single frame
        f0  = frames_done;
        fd0 = fd_count;
        send(12'hABC, 12'h123);
        sample_valid = 1'b0;
        wait_done();
        check("single_frames", frames_done - f0, 1);
        check("single_frame_done_pulses", fd_count - fd0, 1);

        // Continuous valid: four pairs
        gaps.delete();
        f0 = frames_done;
        send(12'h5A5, 12'h3C3);
        send(12'hFFF, 12'h000);
        send(12'h000, 12'hFFF);
        send(12'h7E1, 12'h81E);
        sample_valid = 1'b0;
        wait_done();
        check("cont_frames", frames_done - f0, 4);
        check("cont_starts", gaps.size(), 4);
        for (int i = 1; i < gaps.size(); i++) begin
`ifdef DAC_SKID_BUF_EN
            check("cont_sync_high", gaps[i], GAP_S);
`else
            check("cont_sync_high", gaps[i], GAP_S + 1);
`endif
        end

`ifdef DAC_SKID_BUF_EN
        // Back-to-back through the holding register
        gaps.delete();
        send(12'h001, 12'h0AA);
        send(12'h800, 12'h055);
        sample_valid = 1'b0;
        check("skid_ready_drop", int'(ready_s), 0);
        check("skid_busy", int'(busy_s), 1);
        wait_done();
        check("skid_starts", gaps.size(), 2);
        if (gaps.size() == 2) check("skid_sync_high", gaps[1], GAP_S);
        check("skid_ready_back", int'(ready_s), 1);
`endif

        // Reset mid-frame after the 7th falling edge
        send(12'h5A5, 12'h0F0);
        sample_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (nbits < 7 && n < 200);
        check("abort_reached_bit7", nbits, 7);
        fd0 = fd_count;
        rst = 1'b1;
        @(negedge clk);
        check("abort_sync_high", int'(sync_s), 1);
        check("abort_frame_done", int'(fdone_s), 0);
        check("abort_busy", int'(busy_s), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_no_pulse", fd_count - fd0, 0);
        check("abort_sb_cleared", sb.size(), 0);
        f0 = frames_done;
        send(12'hFFF, 12'h000);
        sample_valid = 1'b0;
        wait_done();
        check("post_reset_frames", frames_done - f0, 1);

        // Fast instance: CLK_DIV=1, GAP=1
        sel = 1'b1;
        repeat (2) @(negedge clk);
        f0 = frames_done;
        send(12'h000, 12'hFFF);
        send(12'h801, 12'h7FE);
        sample_valid = 1'b0;
        wait_done();
        check("fast_frames", frames_done - f0, 2);

        check("sb_empty", sb.size(), 0);
        check("no_data_change_sclk_low", low_changes, 0);
        check("frame_done_total", fd_count, frames_done);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
